// File: rtl/update_bin_write_engine.sv
// Update-bin write engine: buffers 512-bit update words in a show-ahead FIFO, writes them to
// consecutive cache lines, then writes a status line and waits for every write response.
module update_bin_write_engine #(
  parameter int DEPTH          = 64,
  parameter int ALMFULL_THRESH = 56,
  parameter int ADDR_W         = 42
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic [ADDR_W-1:0] bin_addr,
  input  logic [ADDR_W-1:0] status_addr,
  input  logic [31:0]       status_count,
  input  logic [511:0]      in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              c1_almfull,
  output logic              c1_valid,
  output logic [ADDR_W-1:0] c1_addr,
  output logic [511:0]      c1_data,
  input  logic              c1_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       num_req,
  output logic [31:0]       num_rsp,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] THRESH_C = (PTR_W+1)'(ALMFULL_THRESH);

  typedef enum logic [1:0] {IDLE, STREAM, STATUS, DRAIN} state_t;
  state_t state, state_nxt;

  logic [511:0]      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop, issue_status, start_acc;
  logic [ADDR_W-1:0] bin_base, status_base, index;
  logic              last_seen, rsp_eq;
  logic [31:0]       num_req_n, num_rsp_n;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign push      = in_valid && !full;
  assign in_ready  = (count < THRESH_C);
  assign busy      = (state != IDLE);
  assign start_acc = (state == IDLE) && start;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    issue_status = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = STREAM;
      STREAM: begin
        if (!empty && !c1_almfull) pop = 1'b1;
        else if (last_seen && empty) state_nxt = STATUS;
      end
      STATUS: begin
        if (!c1_almfull) begin
          issue_status = 1'b1;
          state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (rsp_eq) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next counter values feed the registered compare so DRAIN sees equality one cycle after the last response
  always_comb begin
    num_req_n = num_req + 32'(pop || issue_status);
    num_rsp_n = num_rsp + 32'(c1_rsp_valid && (state != IDLE));
    if (start_acc) begin
      num_req_n = '0;
      num_rsp_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      last_seen   <= 1'b0;
      index       <= '0;
      bin_base    <= '0;
      status_base <= '0;
      num_req     <= '0;
      num_rsp     <= '0;
      rsp_eq      <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      num_req <= num_req_n;
      num_rsp <= num_rsp_n;
      rsp_eq  <= (num_rsp_n == num_req_n);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        index  <= index + ADDR_W'(1);
      end
      if (start_acc) begin
        bin_base    <= bin_addr;
        status_base <= status_addr;
        index       <= '0;
        last_seen   <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (in_valid && full) overflow <= 1'b1;
        if ((state == STREAM) && in_last) last_seen <= 1'b1;
      end
    end
  end

  // Write issue stage: one registered request per pop or status write
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      c1_valid <= 1'b0;
      c1_addr  <= '0;
      c1_data  <= '0;
    end else begin
      c1_valid <= pop || issue_status;
      if (pop) begin
        c1_addr <= bin_base + index;
        c1_data <= mem[rd_ptr];
      end else if (issue_status) begin
        c1_addr <= status_base;
        c1_data <= {416'b0, status_count, 64'h1};
      end
    end
  end

endmodule
